// File: rtl/sram_port_arbiter_pkg.sv
// Shared types and defaults for the two-requester single-port SRAM arbiter.
package sram_port_arbiter_pkg;

    // Arbiter state; the encoding is also driven out on the owner port.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OWN0 = 2'd1,
        ST_OWN1 = 2'd2
    } arb_state_e;

    localparam int unsigned MAXBURST_DEFAULT = 4;

    // Beat counter width able to hold 0..maxburst.
    function automatic int unsigned cnt_width(input int unsigned maxburst);
        return $clog2(maxburst + 1);
    endfunction

endpackage

// File: rtl/sram_port_arbiter_if.sv
// Requester, response and memory-side signals of the arbiter.
interface sram_port_arbiter_if #(
    parameter int unsigned DATAWIDTH = 8,
    parameter int unsigned ADDRWIDTH = 8
);
    logic                 req0_valid;
    logic                 req0_ready;
    logic                 req0_we;
    logic [ADDRWIDTH-1:0] req0_addr;
    logic [DATAWIDTH-1:0] req0_wdata;

    logic                 req1_valid;
    logic                 req1_ready;
    logic                 req1_we;
    logic [ADDRWIDTH-1:0] req1_addr;
    logic [DATAWIDTH-1:0] req1_wdata;

    logic                 rsp0_valid;
    logic                 rsp1_valid;
    logic [DATAWIDTH-1:0] rsp_rdata;

    logic                 mem_en;
    logic                 mem_we;
    logic [ADDRWIDTH-1:0] mem_addr;
    logic [DATAWIDTH-1:0] mem_wdata;
    logic [DATAWIDTH-1:0] mem_rdata;

    logic [1:0]           owner;

    // Arbiter view.
    modport slave (
        input  req0_valid, req0_we, req0_addr, req0_wdata,
        input  req1_valid, req1_we, req1_addr, req1_wdata,
        input  mem_rdata,
        output req0_ready, req1_ready,
        output rsp0_valid, rsp1_valid, rsp_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata,
        output owner
    );

    // Environment view: requesters plus the memory.
    modport master (
        output req0_valid, req0_we, req0_addr, req0_wdata,
        output req1_valid, req1_we, req1_addr, req1_wdata,
        output mem_rdata,
        input  req0_ready, req1_ready,
        input  rsp0_valid, rsp1_valid, rsp_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        input  owner
    );
endinterface

// File: rtl/sram_arb_fsm.sv
// Ownership FSM: grant state, burst beat counter, last-owner pointer, readys.
module sram_arb_fsm
    import sram_port_arbiter_pkg::*;
#(
    parameter int unsigned MAXBURST = MAXBURST_DEFAULT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req0_valid_i,
    input  logic       req1_valid_i,
    output arb_state_e state_o,
    output logic       req0_ready_o,
    output logic       req1_ready_o
);
    localparam int unsigned        CNT_W    = cnt_width(MAXBURST);
    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(MAXBURST - 1);

    arb_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             last_q, last_d;   // 1: requester 1 was served last
    logic             rdy0_q, rdy1_q;

    // Next-state: tie-break on last owner, hand over after MAXBURST beats or on a dropped valid.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (req0_valid_i && req1_valid_i) begin
                    state_d = last_q ? ST_OWN0 : ST_OWN1;
                end else if (req0_valid_i) begin
                    state_d = ST_OWN0;
                end else if (req1_valid_i) begin
                    state_d = ST_OWN1;
                end
            end
            ST_OWN0: begin
                last_d = 1'b0;
                if (req0_valid_i) begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_d = '0;
                        if (req1_valid_i) begin
                            state_d = ST_OWN1;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end else begin
                    cnt_d   = '0;
                    state_d = req1_valid_i ? ST_OWN1 : ST_IDLE;
                end
            end
            ST_OWN1: begin
                last_d = 1'b1;
                if (req1_valid_i) begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_d = '0;
                        if (req0_valid_i) begin
                            state_d = ST_OWN0;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end else begin
                    cnt_d   = '0;
                    state_d = req0_valid_i ? ST_OWN0 : ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // State register; readys are flopped decodes of the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            last_q  <= 1'b1;
            rdy0_q  <= 1'b0;
            rdy1_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            rdy0_q  <= (state_d == ST_OWN0);
            rdy1_q  <= (state_d == ST_OWN1);
        end
    end

    assign state_o      = state_q;
    assign req0_ready_o = rdy0_q;
    assign req1_ready_o = rdy1_q;

endmodule

// File: rtl/sram_port_arbiter.sv
// Two-requester arbiter onto one synchronous-read SRAM port.
module sram_port_arbiter
    import sram_port_arbiter_pkg::*;
#(
    parameter int unsigned DATAWIDTH = 8,
    parameter int unsigned ADDRWIDTH = 8,
    parameter int unsigned MAXBURST  = MAXBURST_DEFAULT
) (
    input  logic                clk,
    input  logic                rst_n,
    sram_port_arbiter_if.slave  bus
);
    arb_state_e           state;
    logic                 rdy0, rdy1;
    logic                 acc0_c, acc1_c;
    logic                 mem_we_c;
    logic [ADDRWIDTH-1:0] mem_addr_c;
    logic [DATAWIDTH-1:0] mem_wdata_c;
    logic                 rsp0_q, rsp1_q;

    sram_arb_fsm #(
        .MAXBURST (MAXBURST)
    ) u_fsm (
        .clk          (clk),
        .rst_n        (rst_n),
        .req0_valid_i (bus.req0_valid),
        .req1_valid_i (bus.req1_valid),
        .state_o      (state),
        .req0_ready_o (rdy0),
        .req1_ready_o (rdy1)
    );

    // Owner mux onto the memory port; everything is zero when no beat is accepted.
    always_comb begin
        acc0_c      = rdy0 & bus.req0_valid;
        acc1_c      = rdy1 & bus.req1_valid;
        mem_we_c    = 1'b0;
        mem_addr_c  = '0;
        mem_wdata_c = '0;
        if (acc0_c) begin
            mem_we_c    = bus.req0_we;
            mem_addr_c  = bus.req0_addr;
            mem_wdata_c = bus.req0_wdata;
        end else if (acc1_c) begin
            mem_we_c    = bus.req1_we;
            mem_addr_c  = bus.req1_addr;
            mem_wdata_c = bus.req1_wdata;
        end
    end

    // Read-response pipeline: one-cycle pulse aligned with the SRAM read latency.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp0_q <= 1'b0;
            rsp1_q <= 1'b0;
        end else begin
            rsp0_q <= acc0_c & ~bus.req0_we;
            rsp1_q <= acc1_c & ~bus.req1_we;
        end
    end

    assign bus.req0_ready = rdy0;
    assign bus.req1_ready = rdy1;
    assign bus.mem_en     = acc0_c | acc1_c;
    assign bus.mem_we     = mem_we_c;
    assign bus.mem_addr   = mem_addr_c;
    assign bus.mem_wdata  = mem_wdata_c;
    assign bus.rsp0_valid = rsp0_q;
    assign bus.rsp1_valid = rsp1_q;
    assign bus.rsp_rdata  = bus.mem_rdata;
    assign bus.owner      = state;

endmodule
